// File: rtl/fsm_param.sv
`default_nettype none
// ============================================================================
// Module      : fsm_param
// Description : Link-layer control FSM for a bank of NUM_FIFOS FIFOs with
//               NUM_CLASS almost-full / almost-empty threshold classes.
//               Sequence: RESET -> INIT -> IDLE <-> ACTIVE, any of IDLE /
//               ACTIVE -> ERROR on a FIFO error, IDLE / ACTIVE -> INIT on a
//               re-initialisation request.
//               Thresholds are captured while in INIT and released only once
//               every class satisfies ae < af. Once in ACTIVE, the FSM drops
//               back to IDLE only after IDLE_HOLD consecutive all-empty cycles.
//               Per-FIFO errors are latched sticky.
// Build macro : ERR_CLEAR_EN - when defined, error_clr in ERROR clears the
//               sticky errors and re-enters INIT. When undefined, ERROR is
//               terminal until reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1                clock, rising edge
//   reset         in   1                asynchronous active-high reset
//   init          in   1                (re)initialisation / threshold load request
//   error_clr     in   1                clear sticky errors and leave ERROR
//   fifo_errors   in   NUM_FIFOS        per-FIFO error pulses
//   fifo_empties  in   NUM_FIFOS        per-FIFO empty flags
//   af_thr_in     in   NUM_CLASS*THR_W  almost-full thresholds, class k at [k*THR_W +: THR_W]
//   ae_thr_in     in   NUM_CLASS*THR_W  almost-empty thresholds, same packing
//   af_thr_out    out  NUM_CLASS*THR_W  captured almost-full thresholds
//   ae_thr_out    out  NUM_CLASS*THR_W  captured almost-empty thresholds
//   error_out     out  NUM_FIFOS        sticky per-FIFO error flags
//   cfg_err_out   out  1                threshold set invalid (some ae >= af)
//   idle_out      out  1                state is IDLE
//   active_out    out  1                state is ACTIVE
//   state_out     out  3                RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
// ============================================================================
module fsm_param #(
   parameter int NUM_FIFOS = 5,
   parameter int NUM_CLASS = 3,
   parameter int THR_W     = 3,
   parameter int IDLE_HOLD = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init,
   input  logic                       error_clr,
   input  logic [NUM_FIFOS-1:0]       fifo_errors,
   input  logic [NUM_FIFOS-1:0]       fifo_empties,
   input  logic [NUM_CLASS*THR_W-1:0] af_thr_in,
   input  logic [NUM_CLASS*THR_W-1:0] ae_thr_in,
   output logic [NUM_CLASS*THR_W-1:0] af_thr_out,
   output logic [NUM_CLASS*THR_W-1:0] ae_thr_out,
   output logic [NUM_FIFOS-1:0]       error_out,
   output logic                       cfg_err_out,
   output logic                       idle_out,
   output logic                       active_out,
   output logic [2:0]                 state_out
);

   // Counter must be able to hold IDLE_HOLD itself (saturation value).
   localparam int CNT_W = (IDLE_HOLD < 2) ? 1 : $clog2(IDLE_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(IDLE_HOLD - 1);
   localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(IDLE_HOLD);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   state_t                     state_q;
   logic [CNT_W-1:0]           hold_cnt_q;
   logic [NUM_CLASS*THR_W-1:0] af_thr_q;
   logic [NUM_CLASS*THR_W-1:0] ae_thr_q;
   logic [NUM_FIFOS-1:0]       error_q;
   logic                       cfg_err_q;

   logic [NUM_CLASS-1:0]       w_cls_bad;
   logic                       w_cfg_bad;
   logic                       w_any_err;
   logic                       w_all_empty;

   // Per-class validity check on the live threshold inputs (unsigned).
   generate
      for (genvar k = 0; k < NUM_CLASS; k++) begin : g_cls_chk
         assign w_cls_bad[k] = (ae_thr_in[k*THR_W +: THR_W] >= af_thr_in[k*THR_W +: THR_W]);
      end
   endgenerate

   assign w_cfg_bad   = |w_cls_bad;
   assign w_any_err   = |fifo_errors;
   assign w_all_empty = &fifo_empties;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RESET;
         hold_cnt_q <= '0;
         af_thr_q   <= '0;
         ae_thr_q   <= '0;
         error_q    <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RESET: begin
               state_q <= ST_INIT;
            end

            // Thresholds track the inputs every cycle; the exit decision uses
            // the same inputs being captured, so a clean exit always leaves
            // cfg_err_out low and the captured set valid.
            ST_INIT: begin
               af_thr_q   <= af_thr_in;
               ae_thr_q   <= ae_thr_in;
               cfg_err_q  <= w_cfg_bad;
               hold_cnt_q <= '0;
               if (!init && !w_cfg_bad) begin
                  state_q <= ST_IDLE;
               end
            end

            ST_IDLE: begin
               hold_cnt_q <= '0;
               error_q    <= error_q | fifo_errors;
               if (w_any_err) begin
                  state_q <= ST_ERROR;
               end else if (init) begin
                  state_q <= ST_INIT;
               end else if (!w_all_empty) begin
                  state_q <= ST_ACTIVE;
               end
            end

            // The count value equals the number of all-empty cycles already
            // seen; the cycle that would make it IDLE_HOLD moves to IDLE.
            ST_ACTIVE: begin
               error_q <= error_q | fifo_errors;
               if (w_any_err) begin
                  state_q <= ST_ERROR;
               end else if (init) begin
                  state_q    <= ST_INIT;
                  hold_cnt_q <= '0;
               end else if (!w_all_empty) begin
                  hold_cnt_q <= '0;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q    <= ST_IDLE;
                  hold_cnt_q <= '0;
               end else if (hold_cnt_q != HOLD_MAX) begin
                  hold_cnt_q <= hold_cnt_q + CNT_W'(1);
               end
            end

            ST_ERROR: begin
`ifdef ERR_CLEAR_EN
               // Clear has priority: an error arriving with the clear is dropped.
               if (error_clr) begin
                  state_q    <= ST_INIT;
                  error_q    <= '0;
                  hold_cnt_q <= '0;
               end else begin
                  error_q <= error_q | fifo_errors;
               end
`else
               error_q <= error_q | fifo_errors;
`endif
            end

            default: begin
               state_q <= ST_RESET;
            end
         endcase
      end
   end

`ifndef ERR_CLEAR_EN
   // error_clr has no function in this build.
   logic w_unused_clr;
   assign w_unused_clr = error_clr;
`endif

   assign af_thr_out  = af_thr_q;
   assign ae_thr_out  = ae_thr_q;
   assign error_out   = error_q;
   assign cfg_err_out = cfg_err_q;
   assign idle_out    = (state_q == ST_IDLE);
   assign active_out  = (state_q == ST_ACTIVE);
   assign state_out   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_param
// Description : Directed self-checking bench for fsm_param (default
//               parameters). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_param;

   logic       clk;
   logic       reset;
   logic       init;
   logic       error_clr;
   logic [4:0] fifo_errors;
   logic [4:0] fifo_empties;
   logic [8:0] af_thr_in;
   logic [8:0] ae_thr_in;
   logic [8:0] af_thr_out;
   logic [8:0] ae_thr_out;
   logic [4:0] error_out;
   logic       cfg_err_out;
   logic       idle_out;
   logic       active_out;
   logic [2:0] state_out;

   int n_cmp;
   int n_bad;

   fsm_param #(
      .NUM_FIFOS (5),
      .NUM_CLASS (3),
      .THR_W     (3),
      .IDLE_HOLD (4)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .error_clr    (error_clr),
      .fifo_errors  (fifo_errors),
      .fifo_empties (fifo_empties),
      .af_thr_in    (af_thr_in),
      .ae_thr_in    (ae_thr_in),
      .af_thr_out   (af_thr_out),
      .ae_thr_out   (ae_thr_out),
      .error_out    (error_out),
      .cfg_err_out  (cfg_err_out),
      .idle_out     (idle_out),
      .active_out   (active_out),
      .state_out    (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; init = 1'b0; error_clr = 1'b0; fifo_errors = 5'b0;
      fifo_empties = 5'b11111; af_thr_in = 9'h1B6; ae_thr_in = 9'h049;
      tick(); tick();
      n_cmp++; if ({af_thr_out, ae_thr_out, error_out, cfg_err_out, idle_out, active_out, state_out} !== 29'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {af_thr_out, ae_thr_out, error_out, cfg_err_out, idle_out, active_out, state_out}); end
      reset = 1'b0; init = 1'b1;
   endtask

   task automatic test_init_load();
      tick();  // RESET -> INIT
      n_cmp++; if (state_out !== 3'd1) begin n_bad++; $display("FAIL reset_to_init: got %0d want 1", state_out); end
      n_cmp++; if (af_thr_out !== 9'h000) begin n_bad++; $display("FAIL thr_not_captured_in_reset: got %h want 000", af_thr_out); end
      tick();  // INIT held by init=1, capture
      n_cmp++; if (state_out !== 3'd1) begin n_bad++; $display("FAIL init_held: got %0d want 1", state_out); end
      n_cmp++; if ({af_thr_out, ae_thr_out} !== {9'h1B6, 9'h049}) begin n_bad++; $display("FAIL thr_capture: got %h/%h want 1b6/049", af_thr_out, ae_thr_out); end
      init = 1'b0;
      tick();  // INIT -> IDLE
      n_cmp++; if ({state_out, idle_out, active_out, cfg_err_out} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL init_to_idle: got st=%0d i=%b a=%b c=%b want st=2 i=1 a=0 c=0", state_out, idle_out, active_out, cfg_err_out); end
   endtask

   task automatic test_cfg_check();
      init = 1'b1; af_thr_in = 9'h1A6; ae_thr_in = 9'h069;  // class1 ae=5 af=4
      tick();  // IDLE -> INIT, thresholds still frozen
      n_cmp++; if ({state_out, af_thr_out} !== {3'd1, 9'h1B6}) begin n_bad++; $display("FAIL idle_init_frozen: got st=%0d af=%h want st=1 af=1b6", state_out, af_thr_out); end
      init = 1'b0;
      tick();
      n_cmp++; if ({state_out, cfg_err_out} !== {3'd1, 1'b1}) begin n_bad++; $display("FAIL cfg_bad_stays: got st=%0d c=%b want st=1 c=1", state_out, cfg_err_out); end
      n_cmp++; if ({af_thr_out, ae_thr_out} !== {9'h1A6, 9'h069}) begin n_bad++; $display("FAIL cfg_bad_capture: got %h/%h want 1a6/069", af_thr_out, ae_thr_out); end
      ae_thr_in = 9'h061;  // class1 ae == af: still invalid
      tick();
      n_cmp++; if ({state_out, cfg_err_out} !== {3'd1, 1'b1}) begin n_bad++; $display("FAIL cfg_equal_bad: got st=%0d c=%b want st=1 c=1", state_out, cfg_err_out); end
      ae_thr_in = 9'h051;  // class1 ae=2 < af=4
      tick();
      n_cmp++; if ({state_out, cfg_err_out, ae_thr_out} !== {3'd2, 1'b0, 9'h051}) begin n_bad++; $display("FAIL cfg_fixed: got st=%0d c=%b ae=%h want st=2 c=0 ae=051", state_out, cfg_err_out, ae_thr_out); end
      af_thr_in = 9'h000;
      tick();
      n_cmp++; if (af_thr_out !== 9'h1A6) begin n_bad++; $display("FAIL idle_thr_frozen: got %h want 1a6", af_thr_out); end
      af_thr_in = 9'h1A6;
   endtask

   task automatic test_activity();
      fifo_empties = 5'b11110;
      tick();
      n_cmp++; if ({state_out, idle_out, active_out} !== {3'd3, 1'b0, 1'b1}) begin n_bad++; $display("FAIL idle_to_active: got st=%0d i=%b a=%b want 3 0 1", state_out, idle_out, active_out); end
      fifo_empties = 5'b11111;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++; if (state_out !== 3'd3) begin n_bad++; $display("FAIL hold_count_%0d: got %0d want 3", i, state_out); end
      end
      tick();
      n_cmp++; if ({state_out, idle_out} !== {3'd2, 1'b1}) begin n_bad++; $display("FAIL hold_done: got st=%0d i=%b want 2 1", state_out, idle_out); end
      // Restart: a non-empty cycle mid-count resets the hold count.
      fifo_empties = 5'b01111;
      tick();
      fifo_empties = 5'b11111;
      tick(); tick();
      fifo_empties = 5'b11011;
      tick();
      fifo_empties = 5'b11111;
      tick(); tick(); tick();
      n_cmp++; if (state_out !== 3'd3) begin n_bad++; $display("FAIL hold_restart_3: got %0d want 3", state_out); end
      tick();
      n_cmp++; if (state_out !== 3'd2) begin n_bad++; $display("FAIL hold_restart_4: got %0d want 2", state_out); end
   endtask

   task automatic test_init_from_active();
      fifo_empties = 5'b11110;
      tick();
      fifo_empties = 5'b11111; init = 1'b1;
      tick();
      n_cmp++; if (state_out !== 3'd1) begin n_bad++; $display("FAIL active_to_init: got %0d want 1", state_out); end
      init = 1'b0; fifo_errors = 5'b10000;  // ignored in INIT
      tick();
      n_cmp++; if ({state_out, error_out} !== {3'd2, 5'b00000}) begin n_bad++; $display("FAIL init_err_ignored: got st=%0d e=%b want st=2 e=00000", state_out, error_out); end
      fifo_errors = 5'b0;
   endtask

   task automatic test_error();
      fifo_empties = 5'b11110;
      tick();
      fifo_empties = 5'b11111; fifo_errors = 5'b00100; init = 1'b1;
      tick();
      n_cmp++; if ({state_out, error_out, idle_out, active_out} !== {3'd4, 5'b00100, 1'b0, 1'b0}) begin n_bad++; $display("FAIL err_beats_init: got st=%0d e=%b i=%b a=%b want 4 00100 0 0", state_out, error_out, idle_out, active_out); end
      fifo_errors = 5'b0;
      tick();
      n_cmp++; if (state_out !== 3'd4) begin n_bad++; $display("FAIL error_init_ignored: got %0d want 4", state_out); end
      init = 1'b0; fifo_errors = 5'b00001;
      tick();
      n_cmp++; if (error_out !== 5'b00101) begin n_bad++; $display("FAIL err_sticky: got %b want 00101", error_out); end
      fifo_errors = 5'b0;
   endtask

   task automatic test_error_clr();
      error_clr = 1'b1; fifo_errors = 5'b01000;
      tick();
`ifdef ERR_CLEAR_EN
      n_cmp++; if ({state_out, error_out} !== {3'd1, 5'b00000}) begin n_bad++; $display("FAIL err_clear: got st=%0d e=%b want st=1 e=00000", state_out, error_out); end
`else
      n_cmp++; if ({state_out, error_out} !== {3'd4, 5'b01101}) begin n_bad++; $display("FAIL err_clr_ignored: got st=%0d e=%b want st=4 e=01101", state_out, error_out); end
`endif
      error_clr = 1'b0; fifo_errors = 5'b0;
   endtask

   task automatic test_async_reset();
`ifdef ERR_CLEAR_EN
      tick();  // INIT -> IDLE
      fifo_empties = 5'b11110;
      tick();  // ACTIVE
      fifo_empties = 5'b11111; fifo_errors = 5'b00010;
      tick();  // ERROR
      fifo_errors = 5'b0;
      n_cmp++; if ({state_out, error_out} !== {3'd4, 5'b00010}) begin n_bad++; $display("FAIL pre_reset_err: got st=%0d e=%b want 4 00010", state_out, error_out); end
`endif
      #1 reset = 1'b1;
      #1;  // well before the next rising edge
      n_cmp++; if ({af_thr_out, ae_thr_out, error_out, cfg_err_out, idle_out, active_out, state_out} !== 29'h0) begin n_bad++; $display("FAIL async_reset_err: got %h want 0", {af_thr_out, ae_thr_out, error_out, cfg_err_out, idle_out, active_out, state_out}); end
      tick();
      reset = 1'b0;
      tick();
      n_cmp++; if (state_out !== 3'd1) begin n_bad++; $display("FAIL reset_release: got %0d want 1", state_out); end
      tick();  // clean thresholds, init=0 -> IDLE
      n_cmp++; if ({state_out, af_thr_out, ae_thr_out} !== {3'd2, 9'h1A6, 9'h051}) begin n_bad++; $display("FAIL reinit_idle: got st=%0d af=%h ae=%h want 2 1a6 051", state_out, af_thr_out, ae_thr_out); end
      fifo_empties = 5'b11110;
      tick();
      n_cmp++; if (state_out !== 3'd3) begin n_bad++; $display("FAIL reactive: got %0d want 3", state_out); end
      #1 reset = 1'b1;
      #1;
      n_cmp++; if ({af_thr_out, ae_thr_out, error_out, cfg_err_out, idle_out, active_out, state_out} !== 29'h0) begin n_bad++; $display("FAIL async_reset_active: got %h want 0", {af_thr_out, ae_thr_out, error_out, cfg_err_out, idle_out, active_out, state_out}); end
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_init_load();
      test_cfg_check();
      test_activity();
      test_init_from_active();
      test_error();
      test_error_clr();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
